// File: rtl/vid_demux_pkg.sv
// Shared types and helpers for the video stream demultiplexer.
package vid_demux_pkg;

  // Resync state, used only when TUSER marks start-of-frame.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SYNC = 1'b1
  } sync_st_e;

  // Reset destination: out-of-range defaults fall back to port 0.
  function automatic int sel_default(int def, int n);
    return (def >= 0 && def < n) ? def : 0;
  endfunction

endpackage

// File: rtl/vid_demux_port.sv
// Single-entry register slice for one output port of the demux.
module vid_demux_port #(
  parameter int PW = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ld_i,
  input  logic [PW-1:0] data_i,
  input  logic          last_i,
  input  logic          user_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o,
  output logic          last_o,
  output logic          user_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q;
  logic          last_q, user_q;

  // A load wins over a drain; otherwise an accepted beat empties the slot.
  always_comb begin
    valid_d = valid_q;
    if (ld_i)         valid_d = 1'b1;
    else if (ready_i) valid_d = 1'b0;
  end

  // Occupancy flag, cleared by reset so a partial frame is abandoned.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  // Payload only moves on a load, so a held beat stays stable.
  always_ff @(posedge clk_i) begin
    if (ld_i) begin
      data_q <= data_i;
      last_q <= last_i;
      user_q <= user_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign user_o  = user_q;

endmodule

// File: rtl/vid_demux.sv
// Frame-aligned 1:NOUT AXI video stream demultiplexer.
module vid_demux
  import vid_demux_pkg::*;
#(
  parameter int NOUT             = 4,
  parameter int LGDIM            = 11,
  parameter int PW               = 24,
  parameter int DEF_SELECT       = 0,
  parameter bit OPT_TUSER_IS_SOF = 1'b0
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     S_VID_VALID,
  output logic                     S_VID_READY,
  input  logic [PW-1:0]            S_VID_DATA,
  input  logic                     S_VID_LAST,
  input  logic                     S_VID_USER,
  output logic [NOUT-1:0]          M_VID_VALID,
  input  logic [NOUT-1:0]          M_VID_READY,
  output logic [NOUT*PW-1:0]       M_VID_DATA,
  output logic [NOUT-1:0]          M_VID_LAST,
  output logic [NOUT-1:0]          M_VID_USER,
  input  logic [$clog2(NOUT)-1:0]  i_select,
  output logic [$clog2(NOUT)-1:0]  o_active
);

  localparam int            SW      = $clog2(NOUT);
  localparam logic [SW-1:0] SEL_RST = SW'(sel_default(DEF_SELECT, NOUT));
  localparam logic [SW:0]   NOUT_W  = (SW+1)'(NOUT);

  // Dimension width is kept only so parameter lists match the sibling blocks.
  logic unused_lgdim;
  assign unused_lgdim = (LGDIM > 0);

  logic [SW-1:0] r_sel_q, r_sel_d;
  logic          at_sof_q, at_sof_d;
  sync_st_e      st_q, st_d;
  logic          sof_beat, syncing, at_sof, sel_ok, do_switch, sel_rdy;
  logic          s_hs, fwd;

  assign sof_beat = S_VID_VALID && S_VID_USER;
  // The SOF beat that ends SYNC is already routed normally on that cycle.
  assign syncing  = (st_q == ST_SYNC) && !sof_beat;

  // SYNC is left on the first presented SOF beat and never re-entered.
  always_comb begin
    st_d = st_q;
    if (st_q == ST_SYNC && sof_beat) st_d = ST_RUN;
  end

  // Resync state register; only SOF framing starts out in SYNC.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) st_q <= OPT_TUSER_IS_SOF ? ST_SYNC : ST_RUN;
    else                st_q <= st_d;
  end

  assign at_sof    = OPT_TUSER_IS_SOF ? sof_beat : at_sof_q;
  assign sel_ok    = {1'b0, i_select} < NOUT_W;
  assign do_switch = at_sof && (i_select != r_sel_q) && sel_ok && !syncing;
  assign sel_rdy   = !M_VID_VALID[r_sel_q] || M_VID_READY[r_sel_q];

  // Discard while syncing, stall one cycle to switch, else follow the selected port.
  always_comb begin
    S_VID_READY = sel_rdy;
    if (syncing)        S_VID_READY = 1'b1;
    else if (do_switch) S_VID_READY = 1'b0;
  end

  assign s_hs = S_VID_VALID && S_VID_READY;
  assign fwd  = s_hs && !syncing;

  // Next destination and frame-boundary tracking.
  always_comb begin
    r_sel_d  = r_sel_q;
    at_sof_d = at_sof_q;
    if (do_switch) r_sel_d  = i_select;
    if (fwd)       at_sof_d = S_VID_LAST;
  end

  // Destination and boundary registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_sel_q  <= SEL_RST;
      at_sof_q <= 1'b1;
    end else begin
      r_sel_q  <= r_sel_d;
      at_sof_q <= at_sof_d;
    end
  end

  assign o_active = r_sel_q;

  for (genvar k = 0; k < NOUT; k++) begin : g_port
    vid_demux_port #(.PW(PW)) u_port (
      .clk_i   (S_AXI_ACLK),
      .rst_ni  (S_AXI_ARESETN),
      .ld_i    (fwd && (r_sel_q == SW'(k))),
      .data_i  (S_VID_DATA),
      .last_i  (S_VID_LAST),
      .user_i  (S_VID_USER),
      .ready_i (M_VID_READY[k]),
      .valid_o (M_VID_VALID[k]),
      .data_o  (M_VID_DATA[k*PW +: PW]),
      .last_o  (M_VID_LAST[k]),
      .user_o  (M_VID_USER[k])
    );
  end

endmodule

// File: tb/tb_vid_demux.sv
// Randomized and directed bench for vid_demux: two instances (VLAST/NOUT=4/DEF=2
// and SOF/NOUT=5/DEF out of range) run in lockstep against a frame-level model.
module tb_vid_demux;

  localparam int PW = 24;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  logic          gclk = 1'b0;
  logic          rst_n;
  logic          sv [2];
  logic          sl [2];
  logic          su [2];
  logic [PW-1:0] sd [2];
  logic [4:0]    mr [2];
  logic [2:0]    isel [2];

  wire             a_srdy, b_srdy;
  wire [3:0]       a_mv, a_ml, a_mu;
  wire [4*PW-1:0]  a_md;
  wire [1:0]       a_act;
  wire [4:0]       b_mv, b_ml, b_mu;
  wire [5*PW-1:0]  b_md;
  wire [2:0]       b_act;

  always #5 gclk = ~gclk;

  vid_demux #(.NOUT(4), .PW(PW), .DEF_SELECT(2), .OPT_TUSER_IS_SOF(1'b0)) u_dut_a (
    .S_AXI_ACLK(gclk), .S_AXI_ARESETN(rst_n),
    .S_VID_VALID(sv[0]), .S_VID_READY(a_srdy), .S_VID_DATA(sd[0]),
    .S_VID_LAST(sl[0]), .S_VID_USER(su[0]),
    .M_VID_VALID(a_mv), .M_VID_READY(mr[0][3:0]), .M_VID_DATA(a_md),
    .M_VID_LAST(a_ml), .M_VID_USER(a_mu),
    .i_select(isel[0][1:0]), .o_active(a_act)
  );

  vid_demux #(.NOUT(5), .PW(PW), .DEF_SELECT(7), .OPT_TUSER_IS_SOF(1'b1)) u_dut_b (
    .S_AXI_ACLK(gclk), .S_AXI_ARESETN(rst_n),
    .S_VID_VALID(sv[1]), .S_VID_READY(b_srdy), .S_VID_DATA(sd[1]),
    .S_VID_LAST(sl[1]), .S_VID_USER(su[1]),
    .M_VID_VALID(b_mv), .M_VID_READY(mr[1]), .M_VID_DATA(b_md),
    .M_VID_LAST(b_ml), .M_VID_USER(b_mu),
    .i_select(isel[1]), .o_active(b_act)
  );

  // instance configuration
  int nout [2]    = '{4, 5};
  bit sofm [2]    = '{1'b0, 1'b1};
  int def_eff [2] = '{2, 0};

  // reference model state
  int    msel [2];
  int    mcnt [2];      // beats accepted into the current frame (VLAST framing)
  bit    msync [2];
  bit    occ [2][5];
  beat_t hb [2][5];
  bit    mrdy [2], msw [2], msyn [2];

  // stimulus generator: 4x2 frames
  int            gbeat [2];
  logic [PW-1:0] gdat [2];

  // bookkeeping
  int   acc [2], drop [2];
  int   rx [2][5];
  logic last_srdy [2];
  int   n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic obs_srdy(int i);
    return (i == 0) ? a_srdy : b_srdy;
  endfunction

  function automatic int obs_act(int i);
    return (i == 0) ? int'(a_act) : int'(b_act);
  endfunction

  // {valid, last, user, data}
  function automatic logic [PW+2:0] obs_port(int i, int k);
    if (i == 0) return {a_mv[k], a_ml[k], a_mu[k], a_md[k*PW +: PW]};
    return {b_mv[k], b_ml[k], b_mu[k], b_md[k*PW +: PW]};
  endfunction

  task automatic clr_rx();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 5; k++) rx[i][k] = 0;
  endtask

  task automatic drive(int i, bit v);
    int b;
    b     = gbeat[i];
    sv[i] = v;
    sd[i] = gdat[i];
    if (sofm[i]) begin
      su[i] = (b == 0);
      sl[i] = (b % 4 == 3);
    end else begin
      su[i] = (b % 4 == 3);
      sl[i] = (b == 7);
    end
  endtask

  // One clock: drive, check ready, update model at the edge, check registered outputs.
  task automatic tick(bit v0, bit v1);
    bit bnd, ok, hs;
    beat_t nb;
    drive(0, v0);
    drive(1, v1);
    #1;
    for (int i = 0; i < 2; i++) begin
      msyn[i] = sofm[i] && msync[i] && !(sv[i] && su[i]);
      bnd     = sofm[i] ? (sv[i] && su[i]) : (mcnt[i] == 0);
      ok      = int'(isel[i]) < nout[i];
      msw[i]  = !msyn[i] && bnd && ok && (int'(isel[i]) != msel[i]);
      mrdy[i] = msyn[i] || (!msw[i] && (!occ[i][msel[i]] || mr[i][msel[i]]));
      last_srdy[i] = obs_srdy(i);
      if (rst_n) begin
        chk($sformatf("s_ready%0d", i), obs_srdy(i), mrdy[i]);
        for (int k = 0; k < nout[i]; k++) begin
          logic [PW+2:0] p;
          p = obs_port(i, k);
          if (p[PW+2] && mr[i][k]) rx[i][k]++;
        end
      end
    end
    @(posedge gclk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        msel[i]  = def_eff[i];
        mcnt[i]  = 0;
        msync[i] = sofm[i];
        for (int k = 0; k < 5; k++) occ[i][k] = 1'b0;
      end else begin
        hs = sv[i] && mrdy[i];
        for (int k = 0; k < nout[i]; k++)
          if (occ[i][k] && mr[i][k]) occ[i][k] = 1'b0;
        if (hs && !msyn[i]) begin
          nb.d = sd[i]; nb.l = sl[i]; nb.u = su[i];
          occ[i][msel[i]] = 1'b1;
          hb[i][msel[i]]  = nb;
          acc[i]++;
          if (!sofm[i]) mcnt[i] = sl[i] ? 0 : mcnt[i] + 1;
        end
        if (hs && msyn[i]) drop[i]++;
        if (hs) begin
          gbeat[i] = (gbeat[i] + 1) % 8;
          gdat[i]  = PW'($urandom);
        end
        if (sofm[i] && msync[i] && sv[i] && su[i]) msync[i] = 1'b0;
        if (msw[i]) msel[i] = int'(isel[i]);
      end
    end
    @(negedge gclk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("active%0d", i), obs_act(i), msel[i]);
      for (int k = 0; k < nout[i]; k++) begin
        logic [PW+2:0] p;
        p = obs_port(i, k);
        chk($sformatf("valid%0d_%0d", i, k), p[PW+2], occ[i][k]);
        if (occ[i][k])
          chk($sformatf("beat%0d_%0d", i, k), p[PW+1:0],
              {hb[i][k].l, hb[i][k].u, hb[i][k].d});
      end
    end
  endtask

  // Stream until nb beats have been forwarded on instance i (bounded).
  task automatic run_frame(int i, int nb, int chg_at, int chg_val, output int nt);
    acc[i] = 0;
    nt     = 0;
    while (acc[i] < nb && nt < 40) begin
      if (acc[i] == chg_at) isel[i] = 3'(chg_val);
      tick(i == 0, i == 1);
      nt++;
    end
    chk($sformatf("frame_beats%0d", i), acc[i], nb);
  endtask

  initial begin
    int nt;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mr[i] = '1; isel[i] = 3'(def_eff[i]);
      gbeat[i] = 0; gdat[i] = PW'($urandom);
      acc[i] = 0; drop[i] = 0;
      msel[i] = def_eff[i]; mcnt[i] = 0; msync[i] = sofm[i];
      for (int k = 0; k < 5; k++) occ[i][k] = 1'b0;
    end
    clr_rx();
    @(negedge gclk);

    // reset state
    tick(0, 0); tick(0, 0);
    chk("rst_act_a", a_act, 2);
    chk("rst_act_b", b_act, 0);
    chk("rst_valid_a", a_mv, 0);
    chk("rst_valid_b", b_mv, 0);
    rst_n = 1'b1;

    // default destination: whole frame lands on port 2, one beat per cycle
    run_frame(0, 8, -1, 0, nt);
    chk("dflt_ticks", nt, 8);
    tick(0, 0); tick(0, 0);
    chk("dflt_rx_p2", rx[0][2], 8);
    chk("dflt_rx_other", rx[0][0] + rx[0][1] + rx[0][3], 0);

    // mid-frame select change: frame on port 0, change to 1 at beat 3
    isel[0] = 3'd0;
    clr_rx();
    run_frame(0, 8, 2, 1, nt);
    chk("mid_act_hold", a_act, 0);
    tick(1, 0);
    chk("mid_bubble", last_srdy[0], 1'b0);
    chk("mid_act_new", a_act, 1);
    chk("mid_rx_p0", rx[0][0], 8);
    run_frame(0, 8, -1, 0, nt);
    chk("mid_next_ticks", nt, 8);
    tick(0, 0); tick(0, 0);
    chk("mid_rx_p1", rx[0][1], 8);

    // backpressure: port 0 holds its LAST beat while the next frame goes to port 3
    isel[0] = 3'd0;
    run_frame(0, 8, -1, 0, nt);
    clr_rx();
    mr[0][0] = 1'b0;
    isel[0]  = 3'd3;
    run_frame(0, 8, -1, 0, nt);
    tick(0, 0); tick(0, 0);
    chk("bp_hold_valid", a_mv[0], 1'b1);
    chk("bp_hold_last", a_ml[0], 1'b1);
    chk("bp_rx_p3", rx[0][3], 8);
    chk("bp_rx_p0_none", rx[0][0], 0);
    mr[0][0] = 1'b1;
    tick(0, 0);
    chk("bp_rx_p0_drain", rx[0][0], 1);
    chk("bp_p0_empty", a_mv[0], 1'b0);

    // SOF instance: first frame, then an out-of-range select costs nothing
    clr_rx();
    isel[1] = 3'd0;
    run_frame(1, 8, -1, 0, nt);
    chk("sof_first_ticks", nt, 8);
    isel[1] = 3'd7;
    run_frame(1, 8, -1, 0, nt);
    chk("oor_ticks", nt, 8);
    chk("oor_act", b_act, 0);
    isel[1] = 3'd4;
    run_frame(1, 8, -1, 0, nt);
    chk("p4_ticks", nt, 9);
    chk("p4_act", b_act, 4);
    tick(0, 0); tick(0, 0);
    chk("p4_rx", rx[1][4], 8);

    // SOF resync: reset with the source 5 beats before its next SOF
    gbeat[1] = 3;
    rst_n = 1'b0;
    tick(0, 0); tick(0, 0);
    rst_n = 1'b1;
    gbeat[0] = 0;
    isel[0] = 3'd2;
    isel[1] = 3'd0;
    drop[1] = 0;
    clr_rx();
    for (int n = 0; n < 5; n++) tick(0, 1);
    chk("sync_drop", drop[1], 5);
    chk("sync_no_out", b_mv, 0);
    tick(0, 1);
    chk("sync_sof_valid", b_mv[0], 1'b1);
    chk("sync_sof_user", b_mu[0], 1'b1);

    // reset while A is presenting beat 4
    run_frame(0, 3, -1, 0, nt);
    rst_n = 1'b0;
    tick(1, 0);
    chk("rst_mid_valid", a_mv, 0);
    chk("rst_mid_act", a_act, 2);
    rst_n = 1'b1;
    gbeat[0] = 0;

    // randomized traffic, backpressure and select changes
    for (int n = 0; n < 3000; n++) begin
      mr[0] = 5'($urandom_range(0, 15));
      mr[1] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) isel[0] = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) isel[1] = 3'($urandom_range(0, 7));
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vid_demux.md
# vid_demux

Routes one AXI video stream to one of `NOUT` downstream video sinks. It is the fan-out counterpart of the video source selector: the destination changes only between frames, so every sink sees whole frames and AXI-stream compliance is preserved on every port. It sits between a single frame producer and several consumers, for example an HDMI capture feeding a framebuffer writer, an overlay path and a network packetizer.

## Interface

**Parameters**
- `NOUT`, default 4: number of output ports; must be ≥ 2.
- `LGDIM`, default 11: reserved width for frame dimension counters; kept for parameter compatibility with the other video blocks.
- `PW`, default 24: pixel width in bits.
- `DEF_SELECT`, default 0: output selected after reset. Values ≥ `NOUT` are treated as 0.
- `OPT_TUSER_IS_SOF`, default 0: framing convention.
  - 1: TUSER = SOF and TLAST = HLAST.
  - 0: TUSER = HLAST and TLAST = VLAST&HLAST.

**Ports**
- `S_AXI_ACLK`, in, 1: the single clock.
- `S_AXI_ARESETN`, in, 1: synchronous, active-low reset.
- `S_VID_VALID`, in, 1: input stream valid.
- `S_VID_READY`, out, 1: input stream ready.
- `S_VID_DATA`, in, PW: input pixel.
- `S_VID_LAST`, in, 1: input TLAST.
- `S_VID_USER`, in, 1: input TUSER.
- `M_VID_VALID`, out, NOUT: per-port valid.
- `M_VID_READY`, in, NOUT: per-port ready.
- `M_VID_DATA`, out, NOUT*PW: port k occupies bits [k*PW +: PW].
- `M_VID_LAST`, out, NOUT: per-port TLAST, passed through unchanged.
- `M_VID_USER`, out, NOUT: per-port TUSER, passed through unchanged.
- `i_select`, in, $clog2(NOUT): requested destination. Out-of-range values are ignored.
- `o_active`, out, $clog2(NOUT): destination currently in effect (`r_sel`).

## Operation

**Destination register `r_sel`**
- Resets to `DEF_SELECT`, or to 0 if `DEF_SELECT` is out of range.

**Frame boundary flag `at_sof`** (1 = next accepted beat begins a frame)
- `OPT_TUSER_IS_SOF=0`:
  - Reset value is 1.
  - On each input handshake: `at_sof <= S_VID_LAST` (LAST marks the final beat of a frame).
- `OPT_TUSER_IS_SOF=1`:
  - `at_sof = S_VID_VALID && S_VID_USER`, i.e. the boundary is the presented SOF beat.

**Switch condition and action**
- `switch` = `at_sof` && `i_select != r_sel` && `i_select < NOUT` && not syncing.
- On a `switch` cycle:
  - `S_VID_READY` = 0.
  - `r_sel <= i_select`.
- This costs exactly one bubble cycle per switch.

**SOF-mode sync state** (`OPT_TUSER_IS_SOF=1` only)
- After reset the upstream source may be mid-frame, so the block enters a SYNC state.
- In SYNC:
  - `S_VID_READY` = 1.
  - Beats are accepted and discarded.
- SYNC exits on the cycle a beat with USER=1 is presented. That beat is not consumed in SYNC; it is routed normally starting that cycle.
- In VLAST mode there is no SYNC state: the source is reset with this block.

**States** (SOF mode): SYNC → RUN. There is no return to SYNC except through reset.

**Ready outside SYNC and switch**
- `S_VID_READY = !M_VID_VALID[r_sel] || M_VID_READY[r_sel]`.

**Per-port output register**
- Load: on an input handshake with `r_sel==k`, port k loads DATA/LAST/USER and sets VALID.
- Clear: VALID clears on `M_VID_READY[k]` with no new load.
- Port registers are independent. A port deselected while holding a beat keeps VALID and the data stable until that beat is accepted; no beat is ever dropped or duplicated.
- Ports other than `r_sel` never load.

## Timing

- Latency: input handshake at cycle n → `M_VID_VALID[r_sel]` at n+1.
- Throughput: 1 beat/cycle when the selected port is ready.
- Reset values: `M_VID_VALID`=0 on all ports; `o_active`=`DEF_SELECT`; `S_VID_READY` follows its combinational rule from the cycle after reset (1 in VLAST mode and in SYNC).
- `M_VID_DATA`/`LAST`/`USER` are don't-care while the corresponding VALID is 0.
- `i_select` change mid-frame: no effect until the boundary.
  - VLAST mode: the cycle after the LAST handshake.
  - SOF mode: the cycle the SOF beat is presented.
- `i_select` changing back before the boundary: no switch occurs.
- Boundary with `i_select==r_sel`: no bubble.
- Reset mid-frame: all port VALIDs clear immediately; a partially forwarded frame is abandoned.
- `S_VID_READY` may depend combinationally on `M_VID_READY[r_sel]`. `M_VID_*` outputs are registered.

## Structure

- No shared package is needed.
- Sub-module `vid_demux_port`: a single-entry register slice holding {DATA, LAST, USER}, with a load enable and VALID/READY. Instantiate NOUT times in a generate loop.
- The top level holds `r_sel`, `at_sof`, the SYNC flag and the `S_VID_READY` mux.

## Test plan

- **Reset default:** `DEF_SELECT=2`, `NOUT=4`; stream a 4x2 frame. Required: all 8 beats appear on port 2 with 1-cycle latency and LAST on beat 8; ports 0, 1 and 3 VALID stay 0.
- **Mid-frame select change:** set `i_select=1` at beat 3 of a frame on port 0. Required: beats 3–8 go to port 0; one bubble after LAST; the next frame starts on port 1; `o_active`=1.
- **Backpressure and drain:** hold `M_VID_READY[0]=0` while switching to port 3. Required:
  - port 0 keeps its last beat (LAST=1) stable until released;
  - the next frame flows on port 3 meanwhile;
  - no beat is lost or duplicated.
- **Out-of-range select:** `NOUT=5`, `i_select=7` at a boundary. Required: no switch, no bubble, `o_active` unchanged.
- **SOF resync:** `OPT_TUSER_IS_SOF=1`; reset while the source is mid-frame with 5 beats left before SOF. Required: those 5 beats are accepted and dropped; the SOF beat is the first beat output on the selected port.
- **Reset mid-frame:** assert reset during beat 4. Required: all `M_VID_VALID`=0 the next cycle; `o_active`=`DEF_SELECT`.
